// File: rtl/rv32im_lsu_align.sv
// rv32im_lsu_align: load/store alignment front end for the non-pipelined
// Wishbone memory stage. It decodes one request by funct3, rejects illegal or
// misaligned accesses without a bus cycle, and replicates store data across
// byte lanes. It issues a one-cycle data-ready pulse and follows the stage's
// busy/err handshake. For loads it extracts and extends the addressed lane.
// Every request ends with a one-cycle done pulse.
module rv32im_lsu_align #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            clear_ni,
  input  logic            req_i,
  output logic            ready_o,
  input  logic            we_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            done_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            fault_o,
  output logic [1:0]      fault_cause_o,
  output logic [XLEN-1:0] fault_addr_o,
  output logic            mem_data_ready_o,
  output logic [XLEN-1:0] mem_data_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [1:0]      mem_word_size_o,
  output logic            mem_write_o,
  input  logic            mem_busy_i,
  input  logic            mem_err_i,
  input  logic [XLEN-1:0] mem_data_i
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_END   = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_BUS_ERR   = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL   = 2'b11;

  logic [2:0]      state_reg, state_next;
  logic            we_reg;
  logic [2:0]      funct3_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] mem_data_reg;
  logic            err_reg;
  logic [XLEN-1:0] rdata_reg;
  logic            fault_reg;
  logic [1:0]      cause_reg;
  logic [XLEN-1:0] fault_addr_reg;

  // ---------------------------------------------------------------------------
  // Request decode (evaluated on the incoming request while idle)
  // ---------------------------------------------------------------------------
  logic accept;
  logic illegal_in;
  logic misaligned_in;

  assign accept = (state_reg == S_IDLE) && req_i;

  // Loads allow LB/LH/LW/LBU/LHU; stores allow only SB/SH/SW.
  assign illegal_in = we_i ? (funct3_i[2] || (funct3_i[1:0] == 2'b11))
                           : ((funct3_i == 3'b011) || (funct3_i[2:1] == 2'b11));

  assign misaligned_in = ((funct3_i[1:0] == 2'b01) && addr_i[0]) ||
                         ((funct3_i[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));

  // ---------------------------------------------------------------------------
  // Store data replication: the memory stage's byte select picks the lane,
  // so the narrow value simply has to appear in every lane.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] sb_rep;
  logic [XLEN-1:0] sh_rep;
  logic [XLEN-1:0] store_data;

  for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_sb_rep
    assign sb_rep[8*gi +: 8] = wdata_i[7:0];
  end

  for (genvar gi = 0; gi < XLEN / 16; gi++) begin : g_sh_rep
    assign sh_rep[16*gi +: 16] = wdata_i[15:0];
  end

  // Pick the replicated pattern matching the access size.
  always_comb begin
    store_data = wdata_i;
    case (funct3_i[1:0])
      2'b00:   store_data = sb_rep;
      2'b01:   store_data = sh_rep;
      default: store_data = wdata_i;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Load extraction from the raw word returned by the memory stage
  // ---------------------------------------------------------------------------
  logic [7:0]      lane [XLEN/8];
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic            byte_sign;
  logic            half_sign;
  logic [XLEN-1:0] load_data;

  for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_lane
    assign lane[gi] = mem_data_i[8*gi +: 8];
  end

  assign byte_sel  = lane[addr_reg[1:0]];
  assign half_sel  = addr_reg[1] ? mem_data_i[31:16] : mem_data_i[15:0];
  assign byte_sign = ~funct3_reg[2] & byte_sel[7];
  assign half_sign = ~funct3_reg[2] & half_sel[15];

  // Sign- or zero-extend the selected lane according to funct3.
  always_comb begin
    load_data = mem_data_i;
    case (funct3_reg[1:0])
      2'b00:   load_data = {{(XLEN-8){byte_sign}}, byte_sel};
      2'b01:   load_data = {{(XLEN-16){half_sign}}, half_sel};
      default: load_data = mem_data_i;
    endcase
  end

  // A bus error counts only on the rising edge of the sticky err line.
  logic bus_err;
  assign bus_err = mem_err_i & ~err_reg;

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state logic for the request sequence.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:       if (req_i) state_next = (illegal_in || misaligned_in) ? S_DONE : S_ISSUE;
      S_ISSUE:      state_next = S_WAIT_START;
      S_WAIT_START: if (mem_busy_i) state_next = S_WAIT_END;
      S_WAIT_END:   if (!mem_busy_i) state_next = S_DONE;
      S_DONE:       state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // State register and sticky-error history.
  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_reg <= S_IDLE;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      err_reg   <= mem_err_i;
    end
  end

  // Capture the request on acceptance; these drive the memory stage until done.
  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      we_reg       <= 1'b0;
      funct3_reg   <= 3'b000;
      addr_reg     <= '0;
      mem_data_reg <= '0;
    end else if (accept) begin
      we_reg       <= we_i;
      funct3_reg   <= funct3_i;
      addr_reg     <= addr_i;
      mem_data_reg <= we_i ? store_data : '0;
    end
  end

  // Result registers, written only on entry to DONE and held afterwards.
  always_ff @(posedge clk_i or negedge clear_ni) begin
    if (!clear_ni) begin
      rdata_reg      <= '0;
      fault_reg      <= 1'b0;
      cause_reg      <= CAUSE_NONE;
      fault_addr_reg <= '0;
    end else if (accept && (illegal_in || misaligned_in)) begin
      rdata_reg      <= '0;
      fault_reg      <= 1'b1;
      cause_reg      <= illegal_in ? CAUSE_ILLEGAL : CAUSE_MISALIGN;
      fault_addr_reg <= addr_i;
    end else if ((state_reg == S_WAIT_END) && !mem_busy_i) begin
      if (bus_err) begin
        rdata_reg      <= '0;
        fault_reg      <= 1'b1;
        cause_reg      <= CAUSE_BUS_ERR;
        fault_addr_reg <= addr_reg;
      end else begin
        rdata_reg      <= we_reg ? '0 : load_data;
        fault_reg      <= 1'b0;
        cause_reg      <= CAUSE_NONE;
        fault_addr_reg <= '0;
      end
    end
  end

  assign ready_o          = (state_reg == S_IDLE);
  assign done_o           = (state_reg == S_DONE);
  assign mem_data_ready_o = (state_reg == S_ISSUE);
  assign mem_addr_o       = addr_reg;
  assign mem_word_size_o  = funct3_reg[1:0];
  assign mem_write_o      = we_reg;
  assign mem_data_o       = mem_data_reg;
  assign rdata_o          = rdata_reg;
  assign fault_o          = fault_reg;
  assign fault_cause_o    = cause_reg;
  assign fault_addr_o     = fault_addr_reg;

endmodule

// File: tb/tb_rv32im_lsu_align.sv
// Directed bench for rv32im_lsu_align: a vector table of single requests
// plus hand-written sequences for held requests and mid-operation reset.
module tb_rv32im_lsu_align;

  logic        clk_i = 1'b0;
  logic        clear_ni;
  logic        req_i;
  logic        ready_o;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic        done_o;
  logic [31:0] rdata_o;
  logic        fault_o;
  logic [1:0]  fault_cause_o;
  logic [31:0] fault_addr_o;
  logic        mem_data_ready_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_addr_o;
  logic [1:0]  mem_word_size_o;
  logic        mem_write_o;
  logic        mem_busy_i;
  logic        mem_err_i;
  logic [31:0] mem_data_i;

  rv32im_lsu_align #(.XLEN(32)) dut (
    .clk_i            (clk_i),
    .clear_ni         (clear_ni),
    .req_i            (req_i),
    .ready_o          (ready_o),
    .we_i             (we_i),
    .funct3_i         (funct3_i),
    .addr_i           (addr_i),
    .wdata_i          (wdata_i),
    .done_o           (done_o),
    .rdata_o          (rdata_o),
    .fault_o          (fault_o),
    .fault_cause_o    (fault_cause_o),
    .fault_addr_o     (fault_addr_o),
    .mem_data_ready_o (mem_data_ready_o),
    .mem_data_o       (mem_data_o),
    .mem_addr_o       (mem_addr_o),
    .mem_word_size_o  (mem_word_size_o),
    .mem_write_o      (mem_write_o),
    .mem_busy_i       (mem_busy_i),
    .mem_err_i        (mem_err_i),
    .mem_data_i       (mem_data_i)
  );

  always #5 clk_i = ~clk_i;

  int passed = 0;
  int total  = 0;

  // Slave behaviour knobs, written only by the main test process.
  int          slave_wait = 0;
  logic [31:0] slave_word = 32'h0;
  bit          slave_err  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  // Memory-stage model: busy rises the cycle after the data-ready pulse,
  // stays high for 1 + wait cycles, then drops with the read word (and the
  // sticky err line if requested). Shares the clear with the DUT.
  initial begin
    mem_busy_i = 1'b0;
    mem_err_i  = 1'b0;
    mem_data_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (!clear_ni) begin
        mem_busy_i = 1'b0;
        mem_err_i  = 1'b0;
      end else if (mem_data_ready_o) begin
        @(posedge clk_i);
        #1;
        if (clear_ni) mem_busy_i = 1'b1;
        for (int i = 0; i <= slave_wait && clear_ni; i++) @(posedge clk_i);
        #1;
        mem_busy_i = 1'b0;
        if (clear_ni) begin
          mem_data_i = slave_word;
          if (slave_err) mem_err_i = 1'b1;
        end
      end
    end
  end

  // Hard time limit so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  // One request: drive before the accept edge, then watch each cycle until
  // done_o (bounded). Memory-side outputs are sampled on the data-ready pulse.
  task automatic run_req(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit hold,
                         output int lat, output int pulses, output int first_pulse,
                         output int ready_low, output logic done_after,
                         output logic [31:0] m_addr, output logic [31:0] m_data,
                         output logic [1:0] m_size, output logic m_write,
                         output logic [31:0] r_data, output logic r_fault,
                         output logic [1:0] r_cause, output logic [31:0] r_faddr);
    lat = 0; pulses = 0; first_pulse = -1; ready_low = 0;
    m_addr = 32'h0; m_data = 32'h0; m_size = 2'b00; m_write = 1'b0;
    r_data = 32'h0; r_fault = 1'b0; r_cause = 2'b00; r_faddr = 32'h0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd;
    @(posedge clk_i);
    #1;
    if (!hold) req_i = 1'b0;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk_i);
      if (!ready_o) ready_low++;
      if (mem_data_ready_o) begin
        pulses++;
        if (first_pulse < 0) begin
          first_pulse = n;
          m_addr = mem_addr_o; m_data = mem_data_o;
          m_size = mem_word_size_o; m_write = mem_write_o;
        end
      end
      if (done_o) begin
        lat = n;
        r_data = rdata_o; r_fault = fault_o; r_cause = fault_cause_o; r_faddr = fault_addr_o;
        break;
      end
    end
    req_i = 1'b0;
    @(negedge clk_i);
    done_after = done_o;
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] sword;
    int          swait;
    bit          serr;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic [1:0]  exp_cause;
    logic [31:0] exp_faddr;
    int          exp_lat;
    int          exp_pulses;
    logic [31:0] exp_mdata;
  } vec_t;

  function automatic vec_t mk(logic we, logic [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                              logic [31:0] sword, int swait, bit serr,
                              logic [31:0] erd, logic ef, logic [1:0] ec, logic [31:0] efa,
                              int elat, int epul, logic [31:0] emd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.sword = sword;
    v.swait = swait; v.serr = serr; v.exp_rdata = erd; v.exp_fault = ef;
    v.exp_cause = ec; v.exp_faddr = efa; v.exp_lat = elat; v.exp_pulses = epul;
    v.exp_mdata = emd;
    return v;
  endfunction

  localparam int NV = 16;
  vec_t vecs [NV];

  int          lat, pulses, first_pulse, ready_low;
  logic        done_after, m_write, r_fault;
  logic [31:0] m_addr, m_data, r_data, r_faddr;
  logic [1:0]  m_size, r_cause;

  initial begin
    //              we  f3      addr          wdata         slave word    w  e  rdata         flt c      faddr       lat pul mem_data
    vecs[0]  = mk(0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 2'b00, 32'h0,      4, 1, 32'h0);
    vecs[1]  = mk(0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 2'b00, 32'h0,      4, 1, 32'h0);
    vecs[2]  = mk(0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF1234, 0, 0, 32'h00000080, 0, 2'b00, 32'h0,      4, 1, 32'h0);
    vecs[3]  = mk(0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF1234, 0, 0, 32'hFFFF80FF, 0, 2'b00, 32'h0,      4, 1, 32'h0);
    vecs[4]  = mk(0, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF1234, 0, 0, 32'h000080FF, 0, 2'b00, 32'h0,      4, 1, 32'h0);
    vecs[5]  = mk(0, 3'b000, 32'h0000_0100, 32'h0,        32'h80FF1234, 0, 0, 32'h00000034, 0, 2'b00, 32'h0,      4, 1, 32'h0);
    vecs[6]  = mk(0, 3'b010, 32'h0000_0104, 32'h0,        32'h0BADF00D, 2, 0, 32'h0BADF00D, 0, 2'b00, 32'h0,      6, 1, 32'h0);
    vecs[7]  = mk(1, 3'b000, 32'h0000_0201, 32'h123456A5, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 2'b00, 32'h0,      4, 1, 32'hA5A5A5A5);
    vecs[8]  = mk(1, 3'b001, 32'h0000_0202, 32'h1234BEEF, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 2'b00, 32'h0,      4, 1, 32'hBEEFBEEF);
    vecs[9]  = mk(1, 3'b010, 32'h0000_0204, 32'hCAFEBABE, 32'hFFFFFFFF, 0, 0, 32'h0,        0, 2'b00, 32'h0,      4, 1, 32'hCAFEBABE);
    vecs[10] = mk(0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, 0, 32'h0,        1, 2'b01, 32'h102,    1, 0, 32'h0);
    vecs[11] = mk(0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, 0, 32'h0,        1, 2'b11, 32'h100,    1, 0, 32'h0);
    vecs[12] = mk(1, 3'b100, 32'h0000_0300, 32'h11223344, 32'h0,        0, 0, 32'h0,        1, 2'b11, 32'h300,    1, 0, 32'h0);
    vecs[13] = mk(0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, 0, 32'h0,        1, 2'b01, 32'h101,    1, 0, 32'h0);
    vecs[14] = mk(0, 3'b010, 32'h0000_0110, 32'h0,        32'h12345678, 0, 1, 32'h0,        1, 2'b10, 32'h110,    4, 1, 32'h0);
    vecs[15] = mk(0, 3'b010, 32'h0000_0114, 32'h0,        32'h55AA55AA, 0, 0, 32'h55AA55AA, 0, 2'b00, 32'h0,      4, 1, 32'h0);

    req_i = 1'b0; we_i = 1'b0; funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
    clear_ni = 1'b1;
    #2 clear_ni = 1'b0;
    #1;
    chk("rst_ready", {31'h0, ready_o}, 32'h1);
    chk("rst_ctrl", {25'h0, done_o, fault_o, fault_cause_o, mem_data_ready_o, mem_write_o, mem_word_size_o[0] | mem_word_size_o[1]}, 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    chk("rst_faddr", fault_addr_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_data", mem_data_o, 32'h0);
    repeat (2) @(negedge clk_i);
    clear_ni = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < NV; i++) begin
      slave_wait = vecs[i].swait; slave_word = vecs[i].sword; slave_err = vecs[i].serr;
      run_req(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, 1'b0,
              lat, pulses, first_pulse, ready_low, done_after,
              m_addr, m_data, m_size, m_write, r_data, r_fault, r_cause, r_faddr);
      $display("txn %0d we=%0b f3=%03b addr=%08h lat=%0d rdata=%08h fault=%0b cause=%0d faddr=%08h",
               i, vecs[i].we, vecs[i].f3, vecs[i].addr, lat, r_data, r_fault, r_cause, r_faddr);
      chk($sformatf("row%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("row%0d_pulses", i), pulses, vecs[i].exp_pulses);
      chk($sformatf("row%0d_ready_low", i), ready_low, vecs[i].exp_lat);
      chk($sformatf("row%0d_rdata", i), r_data, vecs[i].exp_rdata);
      chk($sformatf("row%0d_fault", i), {31'h0, r_fault}, {31'h0, vecs[i].exp_fault});
      chk($sformatf("row%0d_cause", i), {30'h0, r_cause}, {30'h0, vecs[i].exp_cause});
      chk($sformatf("row%0d_faddr", i), r_faddr, vecs[i].exp_faddr);
      chk($sformatf("row%0d_done_width", i), {31'h0, done_after}, 32'h0);
      if (vecs[i].exp_pulses != 0) begin
        chk($sformatf("row%0d_issue_cycle", i), first_pulse, 1);
        chk($sformatf("row%0d_mem_addr", i), m_addr, vecs[i].addr);
        chk($sformatf("row%0d_mem_size", i), {30'h0, m_size}, {30'h0, vecs[i].f3[1:0]});
        chk($sformatf("row%0d_mem_write", i), {31'h0, m_write}, {31'h0, vecs[i].we});
        chk($sformatf("row%0d_mem_data", i), m_data, vecs[i].exp_mdata);
      end
    end

    // req_i held high through a one-wait-state LW: exactly one bus cycle.
    slave_wait = 1; slave_word = 32'h13579BDF; slave_err = 1'b0;
    run_req(1'b0, 3'b010, 32'h0000_0118, 32'h0, 1'b1,
            lat, pulses, first_pulse, ready_low, done_after,
            m_addr, m_data, m_size, m_write, r_data, r_fault, r_cause, r_faddr);
    $display("txn hold lat=%0d pulses=%0d rdata=%08h cause=%0d", lat, pulses, r_data, r_cause);
    chk("hold_latency", lat, 5);
    chk("hold_pulses", pulses, 1);
    chk("hold_ready_low", ready_low, 5);
    chk("hold_rdata", r_data, 32'h13579BDF);
    chk("hold_cause", {30'h0, r_cause}, 32'h0);
    chk("hold_idle_after", {31'h0, ready_o}, 32'h1);

    // Asynchronous clear while waiting on a three-wait-state slave.
    slave_wait = 3; slave_word = 32'hA1B2C3D4; slave_err = 1'b0;
    @(negedge clk_i);
    req_i = 1'b1; we_i = 1'b0; funct3_i = 3'b010; addr_i = 32'h0000_011C; wdata_i = 32'h0;
    @(posedge clk_i);
    #1 req_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rst_mid_busy_before", {31'h0, ready_o}, 32'h0);
    #2 clear_ni = 1'b0;
    #1;
    $display("txn reset ready=%0b done=%0b rdata=%08h mem_addr=%08h", ready_o, done_o, rdata_o, mem_addr_o);
    chk("rst_mid_ready", {31'h0, ready_o}, 32'h1);
    chk("rst_mid_ctrl", {25'h0, done_o, fault_o, fault_cause_o, mem_data_ready_o, mem_write_o, mem_word_size_o[0] | mem_word_size_o[1]}, 32'h0);
    chk("rst_mid_rdata", rdata_o, 32'h0);
    chk("rst_mid_mem_addr", mem_addr_o, 32'h0);
    repeat (2) @(negedge clk_i);
    clear_ni = 1'b1;
    @(negedge clk_i);

    slave_wait = 0; slave_word = 32'h76543210; slave_err = 1'b0;
    run_req(1'b0, 3'b010, 32'h0000_0120, 32'h0, 1'b0,
            lat, pulses, first_pulse, ready_low, done_after,
            m_addr, m_data, m_size, m_write, r_data, r_fault, r_cause, r_faddr);
    $display("txn post_reset lat=%0d rdata=%08h cause=%0d", lat, r_data, r_cause);
    chk("post_rst_latency", lat, 4);
    chk("post_rst_rdata", r_data, 32'h76543210);
    chk("post_rst_fault", {31'h0, r_fault}, 32'h0);
    chk("post_rst_mem_addr", m_addr, 32'h0000_0120);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/rv32im_lsu_align.md
Name: rv32im_lsu_align

Overview:
- Load/store alignment front end sitting directly upstream of the non-pipelined Wishbone memory stage (rv32im_memory_nopipe).
- Accepts one load/store request from execute, decoded by funct3.
- Rejects misaligned or illegal accesses without a bus cycle.
- Replicates store data into byte lanes, issues a single-cycle data-ready pulse to the memory stage, and tracks its busy/err handshake.
- Extracts and sign/zero-extends the loaded lane, then returns the result with a one-cycle done pulse.

Parameters:
XLEN, 32, data/address width; only 32 is supported.

Ports:
clk_i  in  1  clock, rising edge
clear_ni  in  1  asynchronous active-low reset
req_i  in  1  request valid from execute
ready_o  out  1  block idle and able to accept req_i
we_i  in  1  1 = store, 0 = load
funct3_i  in  3  RV32 load/store funct3
addr_i  in  XLEN  byte address
wdata_i  in  XLEN  store data (rs2)
done_o  out  1  one-cycle completion pulse
rdata_o  out  XLEN  load result; 0 for stores and faults
fault_o  out  1  completed with fault; valid with done_o
fault_cause_o  out  2  00 none, 01 misaligned, 10 bus error, 11 illegal funct3
fault_addr_o  out  XLEN  address of the faulting access
mem_data_ready_o  out  1  to memory stage data_ready_i
mem_data_o  out  XLEN  to memory stage data_i
mem_addr_o  out  XLEN  to memory stage addr_i
mem_word_size_o  out  2  to memory stage word_size_i
mem_write_o  out  1  to memory stage write_i
mem_busy_i  in  1  from memory stage busy_o
mem_err_i  in  1  from memory stage err_o (sticky)
mem_data_i  in  XLEN  from memory stage data_o (raw word)

Behaviour:
- Reset (clear_ni low, asynchronous):
  - state = IDLE; ready_o = 1.
  - All other outputs are 0, including err_q.
- Reset mid-operation aborts immediately; clear_ni must be tied to the memory stage clear so both return to idle together.

FSM states and transitions:
- IDLE: ready_o = 1. On req_i, capture we_i, funct3_i, addr_i, wdata_i.
  - Illegal: loads with funct3 011, 110 or 111; stores with funct3[2] = 1 or funct3 = 011. Go to DONE with cause 11.
  - Misaligned: half-word with addr[0] = 1, or word with addr[1:0] != 0. Go to DONE with cause 01.
  - Otherwise go to ISSUE.
- ISSUE: mem_data_ready_o = 1 for exactly this one cycle; go to WAIT_START.
- WAIT_START: wait for mem_busy_i = 1, then go to WAIT_END.
- WAIT_END: on mem_busy_i = 0, go to DONE.
  - If mem_err_i & ~err_q, cause = 10; otherwise cause = 00 and capture the load result.
- DONE: done_o = 1 for one cycle; return to IDLE.
- req_i outside IDLE is ignored. A request is accepted no earlier than the cycle after done_o.

Error tracking:
- err_q registers mem_err_i every cycle.
- A bus error is detected only on the rising edge of mem_err_i, because the memory stage's err_o stays high until its clear.

Memory-side outputs:
- mem_addr_o, mem_word_size_o, mem_write_o and mem_data_o are driven from captured values and held stable from ISSUE through DONE.
- mem_word_size_o = funct3[1:0].
- Store data: SB = {4{wdata[7:0]}}, SH = {2{wdata[15:0]}}, SW = wdata. The memory stage sel picks the lane.
- Loads drive mem_data_o = 0.

Load extraction from mem_data_i (k = addr[1:0]):
- byte = bits [8k+7:8k].
- half = addr[1] ? [31:16] : [15:0].
- funct3[2] = 0 sign-extends; funct3[2] = 1 zero-extends.

Result registers:
- rdata_o, fault_o, fault_cause_o and fault_addr_o are registered.
- They are updated on entry to DONE and held until the next entry to DONE.
- fault_addr_o = 0 when there is no fault.

Latency (accept edge = e0):
- Legal access with a zero-wait slave: done_o is high in the cycle after e3. Each slave wait state adds 1 cycle.
- Fault without bus cycle: done_o is high in the cycle after e0.

Test Plan:
1. LW addr 0x100, slave acks zero-wait with 0xDEADBEEF -> mem_data_ready_o high exactly 1 cycle after accept, mem_word_size_o = 10, mem_addr_o = 0x100; done_o in 4th cycle; rdata_o = 0xDEADBEEF, fault_o = 0.
2. Load lane extraction with slave word 0x80FF1234:
   - LB 0x103 -> 0xFFFFFF80; LBU 0x103 -> 0x00000080.
   - LH 0x102 -> 0xFFFF80FF; LHU 0x102 -> 0x000080FF.
   - LB 0x100 -> 0x00000034.
3. Stores:
   - SB addr 0x201, wdata 0x123456A5 -> mem_data_o = 0xA5A5A5A5, mem_write_o = 1, mem_word_size_o = 00.
   - SH 0x202, wdata 0xXXXXBEEF -> mem_data_o = 0xBEEFBEEF.
   - Both complete with rdata_o = 0.
4. Rejected accesses:
   - LW 0x102 -> done_o 1 cycle after accept, cause 01, fault_addr_o = 0x102, mem_data_ready_o never asserted.
   - Load funct3 = 011 -> cause 11.
5. Bus error then recovery:
   - Slave err on LW -> done with cause 10.
   - Next LW with mem_err_i still high and normal ack -> cause 00, correct data.
   - req_i held high during WAIT states is not re-accepted.
6. Reset mid-operation: clear_ni low during WAIT_END with 3-cycle slave wait -> all outputs 0 immediately (asynchronous), ready_o = 1; after release, a new LW completes normally.
